// File: rtl/hpi_target_if.sv
// Host-side control strobes of the HPI bus shared by host (master) and device (slave).
// Signals: OTG_ADDR register select, OTG_CS_N/OTG_RD_N/OTG_WR_N active-low strobes,
// OTG_RST_N host reset (active-low), OTG_INT device-to-host interrupt.
// The 16-bit data bus is a separate inout port so its tristate drivers resolve at the top.
interface hpi_target_if;
    logic [1:0] OTG_ADDR;
    logic       OTG_CS_N;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_RST_N;
    logic       OTG_INT;

    modport master (
        output OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
        input  OTG_INT
    );

    modport slave (
        input  OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N,
        output OTG_INT
    );
endinterface

// File: rtl/hpi_target.sv
// HPI device-side responder: word RAM behind an auto-incrementing byte pointer,
// host/device mailboxes and a status register, all reached over the 16-bit HPI bus.
// Ports:
//   Clk, Reset       - clock, synchronous active-high reset
//   bus (slave)      - OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N in; OTG_INT out
//   OTG_DATA         - bidirectional data bus, driven only while a read is being served
//   host_msg_*       - host-to-device mailbox (data/valid out, ack in)
//   dev_msg_*        - device-to-host mailbox (data/wr in, busy out)
module hpi_target #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    hpi_target_if.slave bus,
    inout  wire  [15:0] OTG_DATA,
    output logic [15:0] host_msg_data,
    output logic        host_msg_valid,
    input  logic        host_msg_ack,
    input  logic [15:0] dev_msg_data,
    input  logic        dev_msg_wr,
    output logic        dev_msg_busy
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_MAILBOX = 2'd1;
    localparam logic [1:0] REG_ADDRESS = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WCOMMIT,
        S_RFETCH,
        S_WAIT
    } state_t;

    // Registered bus inputs
    logic        cs_n_q;
    logic        rd_n_q;
    logic        wr_n_q;
    logic        rst_n_q;
    logic [1:0]  addr_q;
    logic [15:0] data_q;
    logic        wr_act_d;
    logic        rd_act_d;

    logic        wr_act;
    logic        rd_act;
    logic        wr_rise;
    logic        rd_rise;
    logic        rst_all;

    state_t      state;
    state_t      state_n;
    logic [15:0] ptr;
    logic [15:0] ptr_n;
    logic        oe;
    logic        oe_n;
    logic [15:0] dout;
    logic [15:0] dout_n;
    logic [15:0] dev_data;
    logic [15:0] dev_data_n;
    logic [15:0] host_data_n;
    logic        host_valid_n;
    logic        dev_busy_n;
    logic        ram_we;
    logic        in_range;

    logic [ADDR_W-1:0] ram_idx;
    logic [15:0]       mem [DEPTH];

    assign wr_act  = !cs_n_q && !wr_n_q && rd_n_q;
    assign rd_act  = !cs_n_q && !rd_n_q && wr_n_q;
    assign wr_rise = wr_act && !wr_act_d;
    assign rd_rise = rd_act && !rd_act_d;
    assign rst_all = Reset || !rst_n_q;

    assign ram_idx  = ptr[ADDR_W:1];
    assign in_range = (ptr >> (ADDR_W + 1)) == 16'd0;

    assign OTG_DATA = oe ? dout : 16'hzzzz;
    assign bus.OTG_INT = dev_msg_busy;

    // Input stage and strobe history; history keeps tracking through reset so a
    // strobe held across reset is not seen as a new access.
    always_ff @(posedge Clk) begin
        cs_n_q   <= bus.OTG_CS_N;
        rd_n_q   <= bus.OTG_RD_N;
        wr_n_q   <= bus.OTG_WR_N;
        rst_n_q  <= bus.OTG_RST_N;
        addr_q   <= bus.OTG_ADDR;
        data_q   <= OTG_DATA;
        wr_act_d <= wr_act;
        rd_act_d <= rd_act;
    end

    // State and register file
    always_ff @(posedge Clk) begin
        if (rst_all) begin
            state          <= S_IDLE;
            ptr            <= 16'd0;
            oe             <= 1'b0;
            dout           <= 16'd0;
            dev_data       <= 16'd0;
            dev_msg_busy   <= 1'b0;
            host_msg_data  <= 16'd0;
            host_msg_valid <= 1'b0;
        end else begin
            state          <= state_n;
            ptr            <= ptr_n;
            oe             <= oe_n;
            dout           <= dout_n;
            dev_data       <= dev_data_n;
            dev_msg_busy   <= dev_busy_n;
            host_msg_data  <= host_data_n;
            host_msg_valid <= host_valid_n;
        end
    end

    // Word RAM; contents survive reset
    always_ff @(posedge Clk) begin
        if (ram_we && !rst_all) begin
            mem[ram_idx] <= data_q;
        end
    end

    // Access FSM; side effects fire on the edge that leaves IDLE (the commit edge)
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        oe_n         = oe;
        dout_n       = dout;
        dev_data_n   = dev_data;
        dev_busy_n   = dev_msg_busy;
        host_data_n  = host_msg_data;
        host_valid_n = host_msg_valid;
        ram_we       = 1'b0;

        // Local side first so a same-cycle host commit can override it
        if (host_msg_ack) begin
            host_valid_n = 1'b0;
        end
        if (dev_msg_wr && !dev_msg_busy) begin
            dev_data_n = dev_msg_data;
            dev_busy_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (wr_rise) begin
                    state_n = S_WCOMMIT;
                    case (addr_q)
                        REG_DATA: begin
                            ram_we = in_range;
                            ptr_n  = ptr + 16'd2;
                        end
                        REG_MAILBOX: begin
                            host_data_n  = data_q;
                            host_valid_n = 1'b1;
                        end
                        REG_ADDRESS: ptr_n = data_q;
                        default: ;
                    endcase
                end else if (rd_rise) begin
                    state_n = S_RFETCH;
                    oe_n    = 1'b1;
                    case (addr_q)
                        REG_DATA: begin
                            dout_n = in_range ? mem[ram_idx] : 16'd0;
                            ptr_n  = ptr + 16'd2;
                        end
                        REG_MAILBOX: begin
                            dout_n = dev_data;
                            // Clearing read beats a same-cycle local write
                            if (dev_msg_busy) begin
                                dev_busy_n = 1'b0;
                                dev_data_n = dev_data;
                            end
                        end
                        REG_ADDRESS: dout_n = ptr;
                        REG_STATUS:  dout_n = {14'd0, host_msg_valid, dev_msg_busy};
                        default: ;
                    endcase
                end
            end
            S_WCOMMIT, S_RFETCH: state_n = S_WAIT;
            S_WAIT: begin
                if (!rd_act) begin
                    oe_n = 1'b0;
                end
                if (!rd_act && !wr_act) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_hpi_target.sv
// Directed self-checking bench for hpi_target: pointer/RAM, both mailboxes,
// out-of-range and wrap behaviour, long strobes, invalid strobes and host reset.
module tb_hpi_target;
    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MBOX = 2'd1;
    localparam logic [1:0] A_ADDR = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tb_data;
    logic        tb_drv;
    wire  [15:0] otg_data;
    logic [15:0] host_msg_data;
    logic        host_msg_valid;
    logic        host_msg_ack;
    logic [15:0] dev_msg_data;
    logic        dev_msg_wr;
    logic        dev_msg_busy;

    int checks = 0;
    int passed = 0;

    hpi_target_if bus ();

    assign otg_data = tb_drv ? tb_data : 16'hzzzz;

    hpi_target #(.ADDR_W(10)) dut (
        .Clk            (clk),
        .Reset          (reset),
        .bus            (bus),
        .OTG_DATA       (otg_data),
        .host_msg_data  (host_msg_data),
        .host_msg_valid (host_msg_valid),
        .host_msg_ack   (host_msg_ack),
        .dev_msg_data   (dev_msg_data),
        .dev_msg_wr     (dev_msg_wr),
        .dev_msg_busy   (dev_msg_busy)
    );

    always #10 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.OTG_ADDR = a; bus.OTG_CS_N = 1'b0; bus.OTG_WR_N = 1'b0;
        tb_data = d; tb_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_WR_N = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(posedge clk); #1;
        bus.OTG_ADDR = a; bus.OTG_CS_N = 1'b0; bus.OTG_RD_N = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        d = otg_data;
        @(posedge clk); #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_RD_N = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic dev_write(input logic [15:0] d);
        @(posedge clk); #1;
        dev_msg_data = d; dev_msg_wr = 1'b1;
        @(posedge clk); #1;
        dev_msg_wr = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] r;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (dut.oe !== 1'b0) $display("FAIL reset_oe got=%b exp=0", dut.oe); else passed++;
        checks++; if (bus.OTG_INT !== 1'b0) $display("FAIL reset_int got=%b exp=0", bus.OTG_INT); else passed++;
        checks++; if (host_msg_valid !== 1'b0) $display("FAIL reset_hvalid got=%b exp=0", host_msg_valid); else passed++;
        checks++; if (dev_msg_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", dev_msg_busy); else passed++;
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0000) $display("FAIL reset_ptr got=%h exp=0000", r); else passed++;
    endtask

    task automatic test_pointer;
        logic [15:0] r;
        bus_write(A_ADDR, 16'h0010);
        bus_write(A_DATA, 16'hAAAA);
        bus_write(A_DATA, 16'h5555);
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0014) $display("FAIL ptr_after_writes got=%h exp=0014", r); else passed++;
        bus_write(A_ADDR, 16'h0010);
        bus_read(A_DATA, r);
        checks++; if (r !== 16'hAAAA) $display("FAIL data_rd0 got=%h exp=AAAA", r); else passed++;
        bus_read(A_DATA, r);
        checks++; if (r !== 16'h5555) $display("FAIL data_rd1 got=%h exp=5555", r); else passed++;
    endtask

    task automatic test_dev_mailbox;
        logic [15:0] r;
        dev_write(16'hBEEF);
        @(negedge clk);
        checks++; if (bus.OTG_INT !== 1'b1) $display("FAIL dev_int_set got=%b exp=1", bus.OTG_INT); else passed++;
        bus_read(A_STAT, r);
        checks++; if (r !== 16'h0001) $display("FAIL dev_status_busy got=%h exp=0001", r); else passed++;
        dev_write(16'h1234);
        bus_read(A_MBOX, r);
        checks++; if (r !== 16'hBEEF) $display("FAIL dev_mbox_rd got=%h exp=BEEF", r); else passed++;
        @(negedge clk);
        checks++; if (bus.OTG_INT !== 1'b0) $display("FAIL dev_int_clr got=%b exp=0", bus.OTG_INT); else passed++;
        bus_read(A_STAT, r);
        checks++; if (r !== 16'h0000) $display("FAIL dev_status_clr got=%h exp=0000", r); else passed++;
    endtask

    task automatic test_host_mailbox;
        // First write: valid rises exactly at the commit edge k+1
        @(posedge clk); #1;
        bus.OTG_ADDR = A_MBOX; bus.OTG_CS_N = 1'b0; bus.OTG_WR_N = 1'b0;
        tb_data = 16'h00C3; tb_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (host_msg_valid !== 1'b0) $display("FAIL host_valid_early got=%b exp=0", host_msg_valid); else passed++;
        @(posedge clk); @(negedge clk);
        checks++; if (host_msg_valid !== 1'b1) $display("FAIL host_valid_k1 got=%b exp=1", host_msg_valid); else passed++;
        checks++; if (host_msg_data !== 16'h00C3) $display("FAIL host_data_k1 got=%h exp=00C3", host_msg_data); else passed++;
        @(posedge clk); #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_WR_N = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        // Second write commits in the same cycle as an ack: write wins
        #1;
        bus.OTG_CS_N = 1'b0; bus.OTG_WR_N = 1'b0; tb_data = 16'h00C4; tb_drv = 1'b1;
        @(posedge clk); #1;
        host_msg_ack = 1'b1;
        @(posedge clk); #1;
        host_msg_ack = 1'b0;
        checks++; if (host_msg_valid !== 1'b1) $display("FAIL host_ack_collide_valid got=%b exp=1", host_msg_valid); else passed++;
        checks++; if (host_msg_data !== 16'h00C4) $display("FAIL host_ack_collide_data got=%h exp=00C4", host_msg_data); else passed++;
        @(posedge clk); #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_WR_N = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        // Plain ack empties the mailbox
        #1 host_msg_ack = 1'b1;
        @(posedge clk); #1 host_msg_ack = 1'b0;
        checks++; if (host_msg_valid !== 1'b0) $display("FAIL host_ack got=%b exp=0", host_msg_valid); else passed++;
    endtask

    task automatic test_range_wrap;
        logic [15:0] r;
        bus_write(A_ADDR, 16'h0000);
        bus_write(A_DATA, 16'h7777);
        bus_write(A_ADDR, 16'h0800);
        bus_write(A_DATA, 16'h1111);
        bus_write(A_ADDR, 16'h0800);
        bus_read(A_DATA, r);
        checks++; if (r !== 16'h0000) $display("FAIL oor_read got=%h exp=0000", r); else passed++;
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0802) $display("FAIL oor_ptr_inc got=%h exp=0802", r); else passed++;
        bus_write(A_ADDR, 16'h0000);
        bus_read(A_DATA, r);
        checks++; if (r !== 16'h7777) $display("FAIL oor_ram_kept got=%h exp=7777", r); else passed++;
        bus_write(A_ADDR, 16'hFFFE);
        bus_write(A_DATA, 16'h2222);
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0000) $display("FAIL ptr_wrap got=%h exp=0000", r); else passed++;
    endtask

    task automatic test_long_strobe;
        logic [15:0] r;
        bus_write(A_ADDR, 16'h0010);
        @(posedge clk); #1;
        bus.OTG_ADDR = A_DATA; bus.OTG_CS_N = 1'b0; bus.OTG_RD_N = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (dut.oe !== 1'b0) $display("FAIL long_oe_before_k1 got=%b exp=0", dut.oe); else passed++;
        @(posedge clk); @(negedge clk);
        checks++; if (otg_data !== 16'hAAAA) $display("FAIL long_data_k1 got=%h exp=AAAA", otg_data); else passed++;
        repeat (8) @(posedge clk);
        #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_RD_N = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (dut.oe !== 1'b1) $display("FAIL long_oe_hold got=%b exp=1", dut.oe); else passed++;
        @(posedge clk); @(negedge clk);
        checks++; if (dut.oe !== 1'b0) $display("FAIL long_oe_release got=%b exp=0", dut.oe); else passed++;
        repeat (2) @(posedge clk);
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0012) $display("FAIL long_one_increment got=%h exp=0012", r); else passed++;
    endtask

    task automatic test_both_strobes;
        logic [15:0] r;
        @(posedge clk); #1;
        bus.OTG_ADDR = A_DATA; bus.OTG_CS_N = 1'b0; bus.OTG_RD_N = 1'b0; bus.OTG_WR_N = 1'b0;
        tb_data = 16'h9999; tb_drv = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.oe !== 1'b0) $display("FAIL both_oe got=%b exp=0", dut.oe); else passed++;
        @(posedge clk); #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_RD_N = 1'b1; bus.OTG_WR_N = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0012) $display("FAIL both_ptr got=%h exp=0012", r); else passed++;
        bus_read(A_DATA, r);
        checks++; if (r !== 16'h5555) $display("FAIL both_ram got=%h exp=5555", r); else passed++;
    endtask

    task automatic test_host_reset;
        logic [15:0] r;
        bus_write(A_ADDR, 16'h0010);
        dev_write(16'hCAFE);
        @(posedge clk); #1;
        bus.OTG_ADDR = A_DATA; bus.OTG_CS_N = 1'b0; bus.OTG_WR_N = 1'b0;
        tb_data = 16'hDEAD; tb_drv = 1'b1; bus.OTG_RST_N = 1'b0;
        @(posedge clk); #1;
        bus.OTG_RST_N = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.OTG_CS_N = 1'b1; bus.OTG_WR_N = 1'b1; tb_drv = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.OTG_INT !== 1'b0) $display("FAIL hrst_int got=%b exp=0", bus.OTG_INT); else passed++;
        checks++; if (host_msg_data !== 16'h0000) $display("FAIL hrst_hdata got=%h exp=0000", host_msg_data); else passed++;
        bus_read(A_ADDR, r);
        checks++; if (r !== 16'h0000) $display("FAIL hrst_ptr got=%h exp=0000", r); else passed++;
        bus_write(A_ADDR, 16'h0010);
        bus_read(A_DATA, r);
        checks++; if (r !== 16'hAAAA) $display("FAIL hrst_ram_kept got=%h exp=AAAA", r); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        tb_data = 16'h0000; tb_drv = 1'b0;
        host_msg_ack = 1'b0; dev_msg_data = 16'h0000; dev_msg_wr = 1'b0;
        bus.OTG_ADDR = 2'd0; bus.OTG_CS_N = 1'b1; bus.OTG_RD_N = 1'b1;
        bus.OTG_WR_N = 1'b1; bus.OTG_RST_N = 1'b1;

        test_reset();
        test_pointer();
        test_dev_mailbox();
        test_host_mailbox();
        test_range_wrap();
        test_long_strobe();
        test_both_strobes();
        test_host_reset();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/hpi_target.md
# hpi_target

Synthesizable responder for the CY7C67200-style host port interface (HPI). It is the device end of the same 16-bit HPI bus that `hpi_io_intf` drives from the NIOS II side. It decodes host read/write strobes into an internal word RAM, an auto-incrementing address pointer, two mailboxes and a status register, and raises `OTG_INT` for device-to-host messages. It is used as an on-chip loopback target and as the bench model for USB host bring-up without the physical chip.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of the internal RAM, which holds 2^ADDR_W x 16 bits.

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: synchronous reset, active-high.
- `OTG_DATA` inout 16: HPI data bus; driven only during an accepted read.
- `OTG_ADDR` in 2: register select. 0 = DATA, 1 = MAILBOX, 2 = ADDRESS, 3 = STATUS.
- `OTG_CS_N` in 1: chip select, active-low.
- `OTG_RD_N` in 1: read strobe, active-low.
- `OTG_WR_N` in 1: write strobe, active-low.
- `OTG_RST_N` in 1: host-driven reset, active-low, sampled synchronously.
- `OTG_INT` out 1: interrupt to host; high while the device-to-host mailbox is full.
- `host_msg_data` out 16: last word the host wrote to MAILBOX.
- `host_msg_valid` out 1: host mailbox full.
- `host_msg_ack` in 1: local consumer pops the host mailbox.
- `dev_msg_data` in 16: local word to send to the host.
- `dev_msg_wr` in 1: load `dev_msg_data` into the device-to-host mailbox.
- `dev_msg_busy` out 1: device-to-host mailbox full; `dev_msg_wr` is ignored while high.

## Operation
- Input stage: `OTG_CS_N`, `OTG_RD_N`, `OTG_WR_N`, `OTG_ADDR` and `OTG_DATA` are registered every cycle.
  - `wr_act` = registered CS low AND WR low AND RD high.
  - `rd_act` = registered CS low AND RD low AND WR high.
  - CS low with both strobes low is no access.
- Access FSM states:
  - IDLE: on a `wr_act` rising edge go to WCOMMIT; on a `rd_act` rising edge go to RFETCH.
  - WCOMMIT: perform the write side effect, then go to WAIT.
  - RFETCH: load `dout`, set `oe`, perform the read side effect, then go to WAIT.
  - WAIT: hold `oe` while `rd_act` is high. When both `rd_act` and `wr_act` are low, clear `oe` and go to IDLE.
  - Exactly one commit happens per strobe assertion, regardless of strobe length.
- Pointer `ptr` is a 16-bit byte address.
  - RAM index is `ptr[ADDR_W:1]`; `ptr[0]` is ignored.
  - In range means `ptr[15:ADDR_W+1]` == 0.
  - After every DATA access, `ptr` += 2, wrapping from 16'hFFFE to 16'h0000.
- Register semantics:
  - DATA write: RAM[ptr] <= data if in range, otherwise dropped; then `ptr` += 2.
  - DATA read: returns RAM[ptr] if in range, otherwise 16'h0000; then `ptr` += 2.
  - MAILBOX write: `host_msg_data` <= data, `host_msg_valid` <= 1. A write while already full overwrites the data; valid stays 1.
  - MAILBOX read: returns the device message register and clears the device mailbox (`dev_msg_busy`, `OTG_INT` -> 0). Reading when empty returns the stale value with no other effect.
  - ADDRESS write: `ptr` <= data. ADDRESS read: returns `ptr`.
  - STATUS read: {14'b0, `host_msg_valid`, `dev_msg_busy`}. STATUS writes are ignored.
- Local side:
  - `host_msg_ack` with valid=1 clears valid on the next edge.
  - A host MAILBOX write commit in the same cycle as an ack wins: valid stays 1 and the new data is stored.
  - `dev_msg_wr` with busy=0 stores the data and sets busy.
  - A device-mailbox-clearing MAILBOX read in the same cycle as `dev_msg_wr` wins: the write is dropped and busy=0 after the edge.
- Reset, from `Reset`=1 or registered `OTG_RST_N`=0:
  - `ptr`=0; both mailboxes empty with data registers = 0; `OTG_INT`=0; `oe`=0 (`OTG_DATA` tri-stated); FSM = IDLE.
  - RAM contents are preserved.
  - Reset mid-access abandons the access with no commit; a strobe still held afterwards is not re-detected until it deasserts.

## Timing
- Edge k: first edge that samples a valid strobe. The commit happens at edge k+1.
- Writes: the RAM or register is updated at edge k+1 and is readable by a read whose edge k is at k+2 or later.
- Reads: `OTG_DATA` is valid from edge k+1 until one cycle after the strobe is sampled high. The host sees data 2 clocks after asserting RD_N, so it must hold RD_N at least 3 cycles.
- `OTG_INT`, `dev_msg_busy` and `host_msg_valid` are registered and change at the commit edge.
- Back-to-back accesses need at least 1 sampled-idle cycle between strobes.

## Test plan
- Reset, then ADDRESS write 16'h0010, then DATA writes 16'hAAAA and 16'h5555, then ADDRESS read → returns 16'h0014. ADDRESS write 16'h0010, then two DATA reads → 16'hAAAA, 16'h5555.
- `dev_msg_wr` with 16'hBEEF → `OTG_INT`=1 and STATUS=16'h0001 the next cycle. A second `dev_msg_wr` with 16'h1234 is ignored. MAILBOX read → 16'hBEEF, then `OTG_INT`=0 and STATUS=16'h0000.
- Host MAILBOX write 16'h00C3 → `host_msg_valid`=1 and `host_msg_data`=16'h00C3 at k+1. Ack in the same cycle as a second write of 16'h00C4 → valid stays 1, data = 16'h00C4.
- With ADDR_W=10: ADDRESS write 16'h0800, DATA write 16'h1111, DATA read at 16'h0800 → 16'h0000 and RAM unchanged. ADDRESS write 16'hFFFE, then one DATA access → `ptr`=16'h0000.
- Hold RD_N low for 10 cycles on DATA → exactly one `ptr` increment; `OTG_DATA` is Z before k+1 and after release. Assert both RD_N and WR_N → no state change and `OTG_DATA`=Z.
- Assert `OTG_RST_N`=0 at edge k of a write → no commit, `ptr`=0, `OTG_INT`=0, and RAM still holds previously written words.
